// File: rtl/rpc2_ctrl_trans_buf.sv
// ---------------------------------------------------------------------------
// rpc2_ctrl_trans_buf
//
// Command buffer sitting directly behind the two-input read/write
// transaction arbiter. A granted command (arb_valid & arb_ready) is muxed
// from the read or write payload according to arb_selector. It is tagged
// with a wrapping sequence number and stored in a small pointer-based FIFO.
// The FIFO head is presented to the RPC2 memory sequencer over a
// valid/ready interface.
//
// Optional feature macro: RPC2_CTRL_TRANS_BUF_BYPASS_EN
//   When defined, an empty buffer forwards the arbiter command to the
//   sequencer combinationally (zero latency). If the sequencer takes it in
//   the same cycle, it is never written to storage; only the tag advances.
//   When undefined, every command passes through storage, giving a fixed
//   one-cycle latency.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst_n          synchronous active-low reset
//   arb_valid      arbiter has a granted command
//   arb_selector   0 = write command, 1 = read command
//   arb_ready      buffer can accept a command (depends on state only)
//   wr_addr/len/id write command payload
//   rd_addr/len/id read command payload
//   cmd_valid      head command valid toward the sequencer
//   cmd_ready      sequencer accepts the head command
//   cmd_write      1 = write, 0 = read
//   cmd_addr/len/id head command payload
//   cmd_tag        sequence tag of the head command
//   buf_count      current occupancy
// ---------------------------------------------------------------------------
module rpc2_ctrl_trans_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arb_valid,
  input  logic                     arb_selector,
  output logic                     arb_ready,
  input  logic [ADDR_WIDTH-1:0]    wr_addr,
  input  logic [LEN_WIDTH-1:0]     wr_len,
  input  logic [ID_WIDTH-1:0]      wr_id,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic [LEN_WIDTH-1:0]     rd_len,
  input  logic [ID_WIDTH-1:0]      rd_id,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     cmd_write,
  output logic [ADDR_WIDTH-1:0]    cmd_addr,
  output logic [LEN_WIDTH-1:0]     cmd_len,
  output logic [ID_WIDTH-1:0]      cmd_id,
  output logic [TAG_WIDTH-1:0]     cmd_tag,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int PTR_W   = IDX_W + 1;
  localparam int ENTRY_W = 1 + ADDR_WIDTH + LEN_WIDTH + ID_WIDTH + TAG_WIDTH;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rpc2_ctrl_trans_buf: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [TAG_WIDTH-1:0] tag_cnt;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] out_entry;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;
  logic bypass_take;

  // Pointers carry one extra wrap bit: equal means empty, equal except for
  // the wrap bit means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

  // Ready is a pure function of the pointer registers so that no
  // combinational path exists from arb_valid or cmd_ready back to the
  // arbiter. A full buffer therefore stalls even if a pop happens now.
  assign arb_ready = ~full;
  assign buf_count = wr_ptr - rd_ptr;

  // Granted command with the tag it will carry; cmd_write is the inverse of
  // the selector.
  always_comb begin
    in_entry = '0;
    if (arb_selector) begin
      in_entry = {1'b0, rd_addr, rd_len, rd_id, tag_cnt};
    end else begin
      in_entry = {1'b1, wr_addr, wr_len, wr_id, tag_cnt};
    end
  end

  assign head_entry = mem[rd_ptr[IDX_W-1:0]];

`ifdef RPC2_CTRL_TRANS_BUF_BYPASS_EN
  // An empty buffer hands the arbiter command straight through. If the
  // sequencer takes it this cycle, it never touches storage.
  assign bypass_take = empty & arb_valid & cmd_ready;
  assign cmd_valid   = empty ? arb_valid : 1'b1;
  assign out_entry   = (empty & arb_valid) ? in_entry : head_entry;
`else
  assign bypass_take = 1'b0;
  assign cmd_valid   = ~empty;
  assign out_entry   = head_entry;
`endif

  assign push  = arb_valid & arb_ready;
  assign pop   = cmd_valid & cmd_ready;
  assign wr_en = push & ~bypass_take;
  assign rd_en = pop & ~empty;

  assign {cmd_write, cmd_addr, cmd_len, cmd_id, cmd_tag} = out_entry;

  // Pointer, tag and storage update. On reset, only the slot that becomes
  // the head is cleared, so the payload outputs read zero afterwards while
  // the rest of the array keeps stale data. Any in-flight handshake is
  // dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      tag_cnt               <= '0;
      mem[{IDX_W{1'b0}}]    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[IDX_W-1:0]] <= in_entry;
        wr_ptr                 <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        tag_cnt <= tag_cnt + TAG_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_rpc2_ctrl_trans_buf.sv
// ---------------------------------------------------------------------------
// tb_rpc2_ctrl_trans_buf
//
// Self-checking bench for rpc2_ctrl_trans_buf in its default build (no
// bypass). A queue-based model of the buffer is updated on every rising
// edge, and a single compare process checks the DUT against it on every
// falling edge. Directed sequences add hand-computed literal expectations.
// A randomized phase then drives traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_rpc2_ctrl_trans_buf;

  localparam int ADDR_WIDTH = 32;
  localparam int LEN_WIDTH  = 8;
  localparam int ID_WIDTH   = 4;
  localparam int DEPTH      = 2;
  localparam int TAG_WIDTH  = 4;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  arb_valid = 1'b0;
  logic                  arb_selector = 1'b0;
  logic                  arb_ready;
  logic [ADDR_WIDTH-1:0] wr_addr = '0;
  logic [LEN_WIDTH-1:0]  wr_len = '0;
  logic [ID_WIDTH-1:0]   wr_id = '0;
  logic [ADDR_WIDTH-1:0] rd_addr = '0;
  logic [LEN_WIDTH-1:0]  rd_len = '0;
  logic [ID_WIDTH-1:0]   rd_id = '0;
  logic                  cmd_valid;
  logic                  cmd_ready = 1'b0;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [TAG_WIDTH-1:0]  cmd_tag;
  logic [CNT_W-1:0]      buf_count;

  rpc2_ctrl_trans_buf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH),
    .ID_WIDTH  (ID_WIDTH),
    .DEPTH     (DEPTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arb_valid   (arb_valid),
    .arb_selector(arb_selector),
    .arb_ready   (arb_ready),
    .wr_addr     (wr_addr),
    .wr_len      (wr_len),
    .wr_id       (wr_id),
    .rd_addr     (rd_addr),
    .rd_len      (rd_len),
    .rd_id       (rd_id),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_id      (cmd_id),
    .cmd_tag     (cmd_tag),
    .buf_count   (buf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [ID_WIDTH-1:0]   id;
    logic [TAG_WIDTH-1:0]  tag;
  } cmd_t;

  cmd_t model_q[$];
  int   model_tag = 0;
  bit   model_live = 1'b0;
  bit   m_push;
  bit   m_pop;
  cmd_t m_cmd;

  int checks_total = 0;
  int checks_passed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a FIFO of at most DEPTH commands. Acceptance
  // requires room before the edge, so a full buffer never pushes even if it
  // pops in the same cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_q.delete();
      model_tag  = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      m_push = arb_valid && (model_q.size() < DEPTH);
      m_pop  = cmd_ready && (model_q.size() > 0);
      if (m_push) begin
        m_cmd.write = ~arb_selector;
        m_cmd.addr  = arb_selector ? rd_addr : wr_addr;
        m_cmd.len   = arb_selector ? rd_len : wr_len;
        m_cmd.id    = arb_selector ? rd_id : wr_id;
        m_cmd.tag   = TAG_WIDTH'(model_tag);
      end
      if (m_pop) begin
        void'(model_q.pop_front());
      end
      if (m_push) begin
        model_q.push_back(m_cmd);
        model_tag = (model_tag + 1) % (1 << TAG_WIDTH);
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("model_arb_ready", 64'(arb_ready), 64'(model_q.size() < DEPTH));
      checkOutput("model_cmd_valid", 64'(cmd_valid), 64'(model_q.size() > 0));
      checkOutput("model_buf_count", 64'(buf_count), 64'(model_q.size()));
      if (model_q.size() > 0) begin
        checkOutput("model_cmd_write", 64'(cmd_write), 64'(model_q[0].write));
        checkOutput("model_cmd_addr", 64'(cmd_addr), 64'(model_q[0].addr));
        checkOutput("model_cmd_len", 64'(cmd_len), 64'(model_q[0].len));
        checkOutput("model_cmd_id", 64'(cmd_id), 64'(model_q[0].id));
        checkOutput("model_cmd_tag", 64'(cmd_tag), 64'(model_q[0].tag));
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  // Drive one arbiter command on the selected side. The unselected side
  // gets random junk so that mux faults show up.
  task automatic applyStimulus(input bit valid, input bit sel,
                               input logic [ADDR_WIDTH-1:0] addr,
                               input logic [LEN_WIDTH-1:0] len,
                               input logic [ID_WIDTH-1:0] id,
                               input bit ready);
    arb_valid    = valid;
    arb_selector = sel;
    cmd_ready    = ready;
    if (sel) begin
      rd_addr = addr;
      rd_len  = len;
      rd_id   = id;
      wr_addr = $urandom;
      wr_len  = LEN_WIDTH'($urandom);
      wr_id   = ID_WIDTH'($urandom);
    end else begin
      wr_addr = addr;
      wr_len  = len;
      wr_id   = id;
      rd_addr = $urandom;
      rd_len  = LEN_WIDTH'($urandom);
      rd_id   = ID_WIDTH'($urandom);
    end
  endtask

  task automatic resetPulse();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    checkOutput("rst_buf_count", 64'(buf_count), 64'd0);
    checkOutput("rst_arb_ready", 64'(arb_ready), 64'd1);
    checkOutput("rst_cmd_write", 64'(cmd_write), 64'd0);
    checkOutput("rst_cmd_addr", 64'(cmd_addr), 64'd0);
    checkOutput("rst_cmd_len", 64'(cmd_len), 64'd0);
    checkOutput("rst_cmd_id", 64'(cmd_id), 64'd0);
    checkOutput("rst_cmd_tag", 64'(cmd_tag), 64'd0);

    // Single write, one-cycle latency.
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h1000, 8'd3, 4'd5, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("t1_cmd_valid", 64'(cmd_valid), 64'd1);
    checkOutput("t1_cmd_write", 64'(cmd_write), 64'd1);
    checkOutput("t1_cmd_addr", 64'(cmd_addr), 64'h1000);
    checkOutput("t1_cmd_len", 64'(cmd_len), 64'd3);
    checkOutput("t1_cmd_id", 64'(cmd_id), 64'd5);
    checkOutput("t1_cmd_tag", 64'(cmd_tag), 64'd0);
    stepCycle();
    checkOutput("t1_drain_valid", 64'(cmd_valid), 64'd0);
    checkOutput("t1_drain_count", 64'(buf_count), 64'd0);

    // Fill with a read then a write, with a third push refused.
    resetPulse();
    applyStimulus(1'b1, 1'b1, 32'h2000, 8'd7, 4'd2, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h3000, 8'd1, 4'd9, 1'b0);
    stepCycle();
    checkOutput("t2_full_count", 64'(buf_count), 64'd2);
    checkOutput("t2_full_ready", 64'(arb_ready), 64'd0);
    applyStimulus(1'b1, 1'b1, 32'h5000, 8'd4, 4'd4, 1'b0);
    stepCycle();
    checkOutput("t2_refused_count", 64'(buf_count), 64'd2);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("t2_first_write", 64'(cmd_write), 64'd0);
    checkOutput("t2_first_addr", 64'(cmd_addr), 64'h2000);
    checkOutput("t2_first_tag", 64'(cmd_tag), 64'd0);
    stepCycle();
    checkOutput("t2_second_write", 64'(cmd_write), 64'd1);
    checkOutput("t2_second_addr", 64'(cmd_addr), 64'h3000);
    checkOutput("t2_second_tag", 64'(cmd_tag), 64'd1);
    stepCycle();
    checkOutput("t2_drain_valid", 64'(cmd_valid), 64'd0);

    // Full buffer with arbiter and sequencer both active: pop only.
    applyStimulus(1'b1, 1'b0, 32'h8000, 8'd0, 4'd1, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 32'h9000, 8'd0, 4'd2, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 32'h6000, 8'd6, 4'd6, 1'b1);
    checkOutput("t3_stall_ready", 64'(arb_ready), 64'd0);
    stepCycle();
    checkOutput("t3_pop_only_count", 64'(buf_count), 64'd1);
    checkOutput("t3_pop_only_ready", 64'(arb_ready), 64'd1);
    checkOutput("t3_pop_only_tag", 64'(cmd_tag), 64'd3);
    stepCycle();
    checkOutput("t3_push_count", 64'(buf_count), 64'd1);
    checkOutput("t3_push_addr", 64'(cmd_addr), 64'h6000);
    checkOutput("t3_push_tag", 64'(cmd_tag), 64'd4);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    stepCycle();
    checkOutput("t3_drain_count", 64'(buf_count), 64'd0);

    // 17 back-to-back commands with alternating selector.
    resetPulse();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'(i % 2), ADDR_WIDTH'(32'h100 * i), LEN_WIDTH'(i), ID_WIDTH'(i), 1'b1);
      stepCycle();
      checkOutput("t4_valid", 64'(cmd_valid), 64'd1);
      checkOutput("t4_tag", 64'(cmd_tag), 64'(i % 16));
      checkOutput("t4_write", 64'(cmd_write), 64'((i % 2) == 0));
      checkOutput("t4_addr", 64'(cmd_addr), 64'(32'h100 * i));
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    stepCycle();
    checkOutput("t4_drain_valid", 64'(cmd_valid), 64'd0);

    // Reset with two entries held and a command mid-handshake.
    applyStimulus(1'b1, 1'b0, 32'hA000, 8'd1, 4'd1, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 32'hB000, 8'd2, 4'd2, 1'b0);
    stepCycle();
    checkOutput("t5_held_count", 64'(buf_count), 64'd2);
    applyStimulus(1'b1, 1'b0, 32'hC000, 8'd3, 4'd3, 1'b1);
    rst_n = 1'b0;
    stepCycle();
    checkOutput("t5_rst_valid", 64'(cmd_valid), 64'd0);
    checkOutput("t5_rst_count", 64'(buf_count), 64'd0);
    checkOutput("t5_rst_ready", 64'(arb_ready), 64'd1);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h7000, 8'd4, 4'd6, 1'b0);
    stepCycle();
    checkOutput("t5_next_valid", 64'(cmd_valid), 64'd1);
    checkOutput("t5_next_addr", 64'(cmd_addr), 64'h7000);
    checkOutput("t5_next_tag", 64'(cmd_tag), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    stepCycle();

    // Randomized traffic with varying backpressure and rare resets.
    for (int i = 0; i < 600; i++) begin
      int ready_pct;
      ready_pct = (i < 200) ? 80 : ((i < 400) ? 30 : 60);
      applyStimulus($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
                    $urandom, LEN_WIDTH'($urandom), ID_WIDTH'($urandom),
                    $urandom_range(0, 99) < ready_pct);
      rst_n = ($urandom_range(0, 79) != 0);
      stepCycle();
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    stepCycle();
    stepCycle();
    stepCycle();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
